// File: rtl/vel_resolver.sv
// vel_resolver: polar-to-Cartesian velocity conversion.
// A quarter-wave sine table is folded into full-circle sine and cosine.
// Both are scaled by the magnitude and delivered through a start/ready/valid handshake.
module vel_resolver #(
    parameter int ANGLE_BITS = 8,
    parameter int AMP_BITS   = 8,
    parameter int MAG_BITS   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ANGLE_BITS-1:0]      angle,
    input  logic [MAG_BITS-1:0]        mag,
    output logic                       ready,
    output logic                       out_valid,
    output logic signed [MAG_BITS:0]   vx,
    output logic signed [MAG_BITS:0]   vy,
    output logic signed [AMP_BITS:0]   sin_o,
    output logic signed [AMP_BITS:0]   cos_o
);

    localparam int Q         = 1 << (ANGLE_BITS - 2);
    localparam int FRAC_BITS = ANGLE_BITS - 2;
    localparam int IDX_BITS  = ANGLE_BITS - 1;
    localparam int PROD_BITS = MAG_BITS + AMP_BITS;

    localparam logic [ANGLE_BITS-1:0] QUARTER_TURN = ANGLE_BITS'(Q);
    localparam logic [IDX_BITS-1:0]   Q_IDX        = IDX_BITS'(Q);
    localparam logic [PROD_BITS-1:0]  ROUND_HALF   = PROD_BITS'(1) << (AMP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_COS,
        RD_SIN,
        MUL
    } state_t;

    // One quarter-table entry, evaluated only at elaboration time.
    function automatic logic [AMP_BITS-1:0] sine_entry(input int k);
        real phase;
        real scaled;
        phase  = 3.14159265358979323846 * real'(k) / (2.0 * real'(Q));
        scaled = $sin(phase) * real'((1 << AMP_BITS) - 1);
        return AMP_BITS'($rtoi(scaled + 0.5));
    endfunction

    // Apply a folded sign to an unsigned scaled magnitude; negating zero stays zero.
    function automatic logic signed [MAG_BITS:0] apply_sign_mag(input logic [MAG_BITS-1:0] m,
                                                                input logic neg);
        return neg ? -$signed({1'b0, m}) : $signed({1'b0, m});
    endfunction

    // Apply a folded sign to a unit table amplitude.
    function automatic logic signed [AMP_BITS:0] apply_sign_amp(input logic [AMP_BITS-1:0] a,
                                                                input logic neg);
        return neg ? -$signed({1'b0, a}) : $signed({1'b0, a});
    endfunction

    state_t state;
    state_t next_state;
    logic   accept;

    logic [AMP_BITS-1:0]   quarter_tbl [0:Q];
    logic [ANGLE_BITS-1:0] angle_r;
    logic [MAG_BITS-1:0]   mag_r;

    logic [ANGLE_BITS-1:0] lookup_angle;
    logic [FRAC_BITS-1:0]  lookup_frac;
    logic [IDX_BITS-1:0]   rd_idx;
    logic                  lookup_sign;

    logic [AMP_BITS-1:0]   rd_data;
    logic                  rd_sign;

    logic [PROD_BITS-1:0]  product;
    logic [MAG_BITS-1:0]   scaled_mag;

    logic [AMP_BITS-1:0]   cos_amp_r;
    logic                  cos_sign_r;
    logic [MAG_BITS-1:0]   cos_scaled_r;

    for (genvar k = 0; k <= Q; k++) begin : g_tbl
        assign quarter_tbl[k] = sine_entry(k);
    end

    // State register; reset returns to IDLE and aborts any computation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, the ready handshake and the operand-latch enable.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = RD_COS;
                end
            end
            RD_COS:  next_state = RD_SIN;
            RD_SIN:  next_state = MUL;
            MUL:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Fold the current lookup into a table index and sign. Cosine reads use angle + Q.
    always_comb begin
        lookup_angle = (state == RD_COS) ? angle_r + QUARTER_TURN : angle_r;
        lookup_frac  = lookup_angle[FRAC_BITS-1:0];
        lookup_sign  = lookup_angle[ANGLE_BITS-1];
        if (lookup_angle[ANGLE_BITS-2]) begin
            rd_idx = Q_IDX - {1'b0, lookup_frac};
        end else begin
            rd_idx = {1'b0, lookup_frac};
        end
    end

    // Registered table read, with the matching folded sign carried alongside.
    always_ff @(posedge clk) begin
        rd_data <= quarter_tbl[rd_idx];
        rd_sign <= lookup_sign;
    end

    // Round-to-nearest scaling of the registered table value by the latched magnitude.
    always_comb begin
        product    = PROD_BITS'(mag_r) * PROD_BITS'(rd_data) + ROUND_HALF;
        scaled_mag = product[PROD_BITS-1:AMP_BITS];
    end

    // Operand latch on accept, so later input changes do not reach the computation in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            angle_r <= angle;
            mag_r   <= mag;
        end
    end

    // Hold the cosine result while the sine read completes.
    always_ff @(posedge clk) begin
        if (state == RD_SIN) begin
            cos_amp_r    <= rd_data;
            cos_sign_r   <= rd_sign;
            cos_scaled_r <= scaled_mag;
        end
    end

    // Output registers: update once per computation and pulse out_valid for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            vx        <= '0;
            vy        <= '0;
            sin_o     <= '0;
            cos_o     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == MUL) begin
                out_valid <= 1'b1;
                vx        <= apply_sign_mag(cos_scaled_r, cos_sign_r);
                vy        <= apply_sign_mag(scaled_mag, rd_sign);
                cos_o     <= apply_sign_amp(cos_amp_r, cos_sign_r);
                sin_o     <= apply_sign_amp(rd_data, rd_sign);
            end
        end
    end

endmodule

// File: tb/tb_vel_resolver.sv
// Testbench for vel_resolver using default parameters (Q=64, T[32]=180, T[64]=255).
// Stimulus pushes hand-computed results into a scoreboard. A monitor pops and compares each result on out_valid.
module tb_vel_resolver;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        angle;
    logic [7:0]        mag;
    logic              ready;
    logic              out_valid;
    logic signed [8:0] vx;
    logic signed [8:0] vy;
    logic signed [8:0] sin_o;
    logic signed [8:0] cos_o;

    typedef struct {
        int vx;
        int vy;
        int s;
        int c;
    } expected_t;

    expected_t sb[$];
    int        checks;
    int        errors;
    bit        prev_valid;

    vel_resolver #(
        .ANGLE_BITS(8),
        .AMP_BITS  (8),
        .MAG_BITS  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .angle    (angle),
        .mag      (mag),
        .ready    (ready),
        .out_valid(out_valid),
        .vx       (vx),
        .vy       (vy),
        .sin_o    (sin_o),
        .cos_o    (cos_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Issue one start pulse and check the ready/out_valid handshake timing.
    task automatic applyStimulus(input int a, input int m, input int evx, input int evy,
                                 input int es, input int ec);
        expected_t e;
        @(negedge clk);
        checkOutput("ready_before_start", int'(ready), 1);
        e.vx = evx; e.vy = evy; e.s = es; e.c = ec;
        sb.push_back(e);
        angle = 8'(a);
        mag   = 8'(m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        angle = 8'(a + 77);
        mag   = 8'(m + 33);
        checkOutput("ready_after_e0", int'(ready), 0);
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("ready_busy", int'(ready), 0);
            checkOutput("valid_early", int'(out_valid), 0);
        end
        @(posedge clk); #1;
        checkOutput("ready_after_e3", int'(ready), 1);
        checkOutput("valid_after_e3", int'(out_valid), 1);
    endtask

    // Wait, with a bound, until every expected result has been seen.
    task automatic drainScoreboard();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        expected_t e;
        if (out_valid) begin
            checkOutput("valid_single_cycle", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got out_valid 1 expected none pending");
            end else begin
                e = sb.pop_front();
                checkOutput("vx", int'(vx), e.vx);
                checkOutput("vy", int'(vy), e.vy);
                checkOutput("sin_o", int'(sin_o), e.s);
                checkOutput("cos_o", int'(cos_o), e.c);
            end
        end
        prev_valid = out_valid;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Main directed sequence.
    initial begin
        expected_t e;
        checks     = 0;
        errors     = 0;
        prev_valid = 1'b0;
        reset      = 1'b1;
        start      = 1'b1;
        angle      = 8'd0;
        mag        = 8'd100;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", int'(ready), 1);
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_vx", int'(vx), 0);
        checkOutput("reset_vy", int'(vy), 0);
        checkOutput("reset_sin", int'(sin_o), 0);
        checkOutput("reset_cos", int'(cos_o), 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        $display("[TB] directed vectors");
        applyStimulus(0,   100,  100,    0,    0,  255);
        applyStimulus(64,  100,    0,  100,  255,    0);
        applyStimulus(128, 100, -100,    0,    0, -255);
        applyStimulus(192, 100,    0, -100, -255,    0);
        applyStimulus(32,  100,   70,   70,  180,  180);
        applyStimulus(160, 100,  -70,  -70, -180, -180);
        applyStimulus(224, 100,   70,  -70, -180,  180);
        applyStimulus(0,   255,  254,    0,    0,  255);
        applyStimulus(32,  0,      0,    0,  180,  180);
        drainScoreboard();

        $display("[TB] start held high");
        @(negedge clk);
        start = 1'b1;
        angle = 8'd64;
        mag   = 8'd100;
        e.vx = 0; e.vy = 100; e.s = 255; e.c = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        angle = 8'd128;
        mag   = 8'd50;
        e.vx = -50; e.vy = 0; e.s = 0; e.c = -255;
        sb.push_back(e);
        checkOutput("held_ready_e0", int'(ready), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held_ready_e3", int'(ready), 1);
        @(posedge clk); #1;
        checkOutput("held_ready_e4", int'(ready), 0);
        angle = 8'd32;
        mag   = 8'd100;
        e.vx = 70; e.vy = 70; e.s = 180; e.c = 180;
        sb.push_back(e);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("held_ready_e8", int'(ready), 0);
        start = 1'b0;
        angle = 8'd0;
        mag   = 8'd0;
        drainScoreboard();

        $display("[TB] reset during RD_SIN");
        @(negedge clk);
        start = 1'b1;
        angle = 8'd96;
        mag   = 8'd80;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_ready", int'(ready), 1);
        checkOutput("abort_valid", int'(out_valid), 0);
        checkOutput("abort_vx", int'(vx), 0);
        checkOutput("abort_vy", int'(vy), 0);
        checkOutput("abort_sin", int'(sin_o), 0);
        checkOutput("abort_cos", int'(cos_o), 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        applyStimulus(224, 100, 70, -70, -180, 180);
        drainScoreboard();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
